// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: CPU load/store, UART debug and data-memory signals around the arbiter
interface dmem_arbiter_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_ack;
  logic [DATA_W-1:0] dbg_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              owner;
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_ack, dbg_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output owner
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_ack, dbg_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  owner
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU and the UART debug bridge;
// CPU has fixed priority, a starvation counter bounds debug latency.
module dmem_arbiter #(
  parameter int ADDR_W       = 7,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  dmem_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t            state_q;
  logic [SW-1:0]     starve_q, starve_d;
  logic              owner_q, mem_en_q, mem_we_q, cpu_ack_q, dbg_ack_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              any_req, dbg_win;
  // a losing dbg_req implies cpu_req was high, so every non-dbg grant with dbg pending counts
  always_comb begin
    any_req  = bus.cpu_req | bus.dbg_req;
    dbg_win  = bus.dbg_req & (~bus.cpu_req | (starve_q >= SW'(STARVE_LIMIT)));
    starve_d = dbg_win ? '0 :
               (bus.dbg_req && starve_q != SW'(STARVE_LIMIT)) ? starve_q + SW'(1) : starve_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q   <= IDLE;
      starve_q  <= '0;
      owner_q   <= 1'b0;
      mem_en_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      cpu_ack_q <= 1'b0;
      dbg_ack_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (any_req) begin
          owner_q  <= dbg_win;
          mem_we_q <= dbg_win ? bus.dbg_we : bus.cpu_we;
          addr_q   <= dbg_win ? bus.dbg_addr : bus.cpu_addr;
          wdata_q  <= dbg_win ? bus.dbg_wdata : bus.cpu_wdata;
          mem_en_q <= 1'b1;
          starve_q <= starve_d;
          state_q  <= ACCESS;
        end
        ACCESS: begin
          mem_en_q  <= 1'b0;
          mem_we_q  <= 1'b0;
          cpu_ack_q <= ~owner_q;
          dbg_ack_q <= owner_q;
          state_q   <= RESP;
        end
        default: begin
          cpu_ack_q <= 1'b0;
          dbg_ack_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.owner     = owner_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.dbg_ack   = dbg_ack_q;
  assign bus.cpu_rdata = cpu_ack_q ? bus.mem_rdata : '0;
  assign bus.dbg_rdata = dbg_ack_q ? bus.mem_rdata : '0;
endmodule
